// File: rtl/tri_bbox_scanner_pkg.sv
// rtl/tri_bbox_scanner_pkg.sv - shared types and helpers for the triangle bounding-box scanner
// Purpose: coordinate/vertex/bbox types, scanner state encoding, screen defaults, min/max helpers.
// Ports: none (package).
package tri_bbox_scanner_pkg;

  localparam int COORD_W           = 10;
  localparam int SCREEN_W_DEFAULT  = 640;
  localparam int SCREEN_H_DEFAULT  = 480;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } vector_t;

  typedef struct packed {
    coord_t xmin;
    coord_t xmax;
    coord_t ymin;
    coord_t ymax;
  } bbox_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BOUND = 2'd1,
    SCAN  = 2'd2
  } scan_state_t;

  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tri_bbox_scanner_if.sv
// rtl/tri_bbox_scanner_if.sv - triangle-in / pixel-out handshake bundle for the scanner
// Purpose: groups the triangle input handshake and the candidate-pixel output handshake.
// Ports (signals): tri_valid/tri_ready + vertex_{a,b,c}{x,y} in; out_valid/out_ready,
//   out_{a,b,c}{x,y}, point_px/py, out_last, tri_skipped, busy out.
// Modports: master = triangle source / pixel sink, slave = scanner.
interface tri_bbox_scanner_if
  import tri_bbox_scanner_pkg::*;
#(
  parameter int WIDTH = COORD_W
);

  logic             tri_valid;
  logic             tri_ready;
  logic [WIDTH-1:0] vertex_ax, vertex_ay, vertex_bx, vertex_by, vertex_cx, vertex_cy;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_ax, out_ay, out_bx, out_by, out_cx, out_cy;
  logic [WIDTH-1:0] point_px, point_py;
  logic             out_last;
  logic             tri_skipped;
  logic             busy;

  modport master (
    output tri_valid, vertex_ax, vertex_ay, vertex_bx, vertex_by, vertex_cx, vertex_cy,
    output out_ready,
    input  tri_ready, out_valid, out_ax, out_ay, out_bx, out_by, out_cx, out_cy,
    input  point_px, point_py, out_last, tri_skipped, busy
  );

  modport slave (
    input  tri_valid, vertex_ax, vertex_ay, vertex_bx, vertex_by, vertex_cx, vertex_cy,
    input  out_ready,
    output tri_ready, out_valid, out_ax, out_ay, out_bx, out_by, out_cx, out_cy,
    output point_px, point_py, out_last, tri_skipped, busy
  );

endinterface

// File: rtl/tri_bbox_scanner_bbox_calc.sv
// rtl/tri_bbox_scanner_bbox_calc.sv - combinational screen-clamped bounding box of three vertices
// Purpose: min/max of the three vertices, max clamped to the last screen column/row.
// Ports: va, vb, vc (vector_t) in; bbox (bbox_t), off_screen out.
module tri_bbox_scanner_bbox_calc
  import tri_bbox_scanner_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEFAULT,
  parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
  input  vector_t va,
  input  vector_t vb,
  input  vector_t vc,
  output bbox_t   bbox,
  output logic    off_screen
);

  localparam coord_t XLIM = coord_t'(SCREEN_W - 1);
  localparam coord_t YLIM = coord_t'(SCREEN_H - 1);

  coord_t xmin, xmax_raw, ymin, ymax_raw;

  always_comb begin
    xmin     = min3(va.x, vb.x, vc.x);
    xmax_raw = max3(va.x, vb.x, vc.x);
    ymin     = min3(va.y, vb.y, vc.y);
    ymax_raw = max3(va.y, vb.y, vc.y);

    bbox.xmin = xmin;
    bbox.xmax = (xmax_raw > XLIM) ? XLIM : xmax_raw;
    bbox.ymin = ymin;
    bbox.ymax = (ymax_raw > YLIM) ? YLIM : ymax_raw;

    // Only the min side can leave the screen entirely; the max side is clamped.
    off_screen = (xmin > XLIM) || (ymin > YLIM);
  end

endmodule

// File: rtl/tri_bbox_scanner.sv
// rtl/tri_bbox_scanner.sv - walks a triangle's clamped bounding box in raster order
// Purpose: accept one triangle, compute its bbox in BOUND, emit one candidate pixel per
//   handshake (x fastest, then y) along with the held vertices.
// Ports: clk, rst (sync, active-high); bus (tri_bbox_scanner_if.slave) carrying the
//   triangle handshake, pixel handshake, out_last, tri_skipped and busy.
module tri_bbox_scanner
  import tri_bbox_scanner_pkg::*;
#(
  parameter int WIDTH    = COORD_W,
  parameter int SCREEN_W = SCREEN_W_DEFAULT,
  parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  tri_bbox_scanner_if.slave   bus
);

  scan_state_t      state_q, state_d;
  vector_t          va_q, vb_q, vc_q;
  bbox_t            bbox_q, bbox_c;
  logic             off_screen;
  logic [WIDTH-1:0] x_q, y_q;
  logic             at_xmax, at_ymax;

  tri_bbox_scanner_bbox_calc #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_bbox_calc (
    .va         (va_q),
    .vb         (vb_q),
    .vc         (vc_q),
    .bbox       (bbox_c),
    .off_screen (off_screen)
  );

  assign at_xmax = (x_q == bbox_q.xmax);
  assign at_ymax = (y_q == bbox_q.ymax);

  assign bus.out_last = (state_q == SCAN) && at_xmax && at_ymax;
  assign bus.point_px = x_q;
  assign bus.point_py = y_q;
  assign bus.out_ax   = va_q.x;
  assign bus.out_ay   = va_q.y;
  assign bus.out_bx   = vb_q.x;
  assign bus.out_by   = vb_q.y;
  assign bus.out_cx   = vc_q.x;
  assign bus.out_cy   = vc_q.y;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    bus.tri_ready   = 1'b0;
    bus.out_valid   = 1'b0;
    bus.tri_skipped = 1'b0;
    bus.busy        = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        // Held low while rst is asserted so nothing is offered as accepted.
        bus.tri_ready = !rst;
        if (bus.tri_valid && !rst) state_d = BOUND;
      end
      BOUND: begin
        if (off_screen) begin
          bus.tri_skipped = 1'b1;
          state_d         = IDLE;
        end else begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready && bus.out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      va_q   <= '0;
      vb_q   <= '0;
      vc_q   <= '0;
      bbox_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      if (state_q == IDLE && bus.tri_valid) begin
        va_q <= '{x: bus.vertex_ax, y: bus.vertex_ay};
        vb_q <= '{x: bus.vertex_bx, y: bus.vertex_by};
        vc_q <= '{x: bus.vertex_cx, y: bus.vertex_cy};
      end
      if (state_q == BOUND) begin
        bbox_q <= bbox_c;
        x_q    <= bbox_c.xmin;
        y_q    <= bbox_c.ymin;
      end
      // On the final pixel the counters simply hold; the FSM leaves SCAN.
      if (state_q == SCAN && bus.out_ready) begin
        if (at_xmax) begin
          if (!at_ymax) begin
            x_q <= bbox_q.xmin;
            y_q <= y_q + 1'b1;
          end
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tri_bbox_scanner.sv
// tb/tb_tri_bbox_scanner.sv - scoreboard bench for the triangle bounding-box scanner
// Purpose: drives triangles, predicts every pixel from a bbox model, compares on handshake.
// Ports: none (top-level bench).
module tb_tri_bbox_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tri_bbox_scanner_if #(.WIDTH(10)) bus ();

  tri_bbox_scanner #(
    .WIDTH    (10),
    .SCREEN_W (640),
    .SCREEN_H (480)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int px;
    int py;
    bit last;
    int ax, ay, bx, by, cx, cy;
  } pix_t;

  pix_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   hs_count = 0;
  bit   last_pending = 0;
  bit   stall_mode = 0;
  int   cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_pix(input int px, input int py, input bit last);
    return {43'd0, 10'(px), 10'(py), last};
  endfunction

  function automatic logic [63:0] pack_verts(input int ax, input int ay, input int bx,
                                             input int by, input int cx, input int cy);
    return {4'd0, 10'(ax), 10'(ay), 10'(bx), 10'(by), 10'(cx), 10'(cy)};
  endfunction

  // Reference model: clamped bbox, raster order, expected pixels appended to the queue.
  task automatic push_tri(input int ax, input int ay, input int bx, input int by,
                          input int cx, input int cy, output int n, output bit skip);
    int xmin, xmax, ymin, ymax;
    pix_t p;
    xmin = ax; if (bx < xmin) xmin = bx; if (cx < xmin) xmin = cx;
    ymin = ay; if (by < ymin) ymin = by; if (cy < ymin) ymin = cy;
    xmax = ax; if (bx > xmax) xmax = bx; if (cx > xmax) xmax = cx;
    ymax = ay; if (by > ymax) ymax = by; if (cy > ymax) ymax = cy;
    if (xmax > 639) xmax = 639;
    if (ymax > 479) ymax = 479;
    skip = (xmin > 639) || (ymin > 479);
    n = 0;
    if (!skip) begin
      for (int y = ymin; y <= ymax; y++) begin
        for (int x = xmin; x <= xmax; x++) begin
          p.px = x; p.py = y; p.last = (x == xmax) && (y == ymax);
          p.ax = ax; p.ay = ay; p.bx = bx; p.by = by; p.cx = cx; p.cy = cy;
          q.push_back(p);
          n++;
        end
      end
    end
  endtask

  // out_ready driver: always 1, or the repeating 1,0,0,1 stall pattern.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.out_ready = stall_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    end
  end

  // Output monitor: every valid cycle must show the scoreboard head; pop on handshake.
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_pending = 0;
      end else begin
        if (last_pending) begin
          check_eq("ready_after_last", {63'd0, bus.tri_ready}, 64'd1);
          check_eq("valid_after_last", {63'd0, bus.out_valid}, 64'd0);
          last_pending = 0;
        end
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            check_eq("extra_pixel_queue_size", 64'(q.size()), 64'd1);
          end else begin
            e = q[0];
            check_eq("pixel", pack_pix(int'(bus.point_px), int'(bus.point_py), bus.out_last),
                     pack_pix(e.px, e.py, e.last));
            check_eq("verts", pack_verts(int'(bus.out_ax), int'(bus.out_ay), int'(bus.out_bx),
                                         int'(bus.out_by), int'(bus.out_cx), int'(bus.out_cy)),
                     pack_verts(e.ax, e.ay, e.bx, e.by, e.cx, e.cy));
            if (bus.out_ready) begin
              void'(q.pop_front());
              hs_count++;
              if (e.last) last_pending = 1;
            end
          end
        end
      end
    end
  end

  task automatic send_tri(input int ax, input int ay, input int bx, input int by,
                          input int cx, input int cy, output int n);
    bit accepted;
    bit skip;
    int t;
    @(posedge clk);
    #1;
    bus.tri_valid = 1'b1;
    bus.vertex_ax = 10'(ax); bus.vertex_ay = 10'(ay);
    bus.vertex_bx = 10'(bx); bus.vertex_by = 10'(by);
    bus.vertex_cx = 10'(cx); bus.vertex_cy = 10'(cy);
    accepted = 0;
    t = 0;
    while (!accepted && t < 3000) begin
      @(negedge clk);
      if (bus.tri_ready) accepted = 1;
      t++;
    end
    if (!accepted) begin
      check_eq("accept_timeout", 64'd0, 64'd1);
      bus.tri_valid = 1'b0;
      n = 0;
    end else begin
      check_eq("accept_queue_empty", 64'(q.size()), 64'd0);
      push_tri(ax, ay, bx, by, cx, cy, n, skip);
      @(posedge clk);
      #1;
      bus.tri_valid = 1'b0;
      @(negedge clk);
      check_eq("bound_busy", {63'd0, bus.busy}, 64'd1);
      check_eq("bound_ready", {63'd0, bus.tri_ready}, 64'd0);
      check_eq("bound_valid", {63'd0, bus.out_valid}, 64'd0);
      check_eq("bound_skipped", {63'd0, bus.tri_skipped}, {63'd0, skip});
      @(negedge clk);
      if (skip) begin
        check_eq("skip_pulse_end", {63'd0, bus.tri_skipped}, 64'd0);
        check_eq("skip_valid", {63'd0, bus.out_valid}, 64'd0);
        check_eq("skip_busy", {63'd0, bus.busy}, 64'd0);
        check_eq("skip_ready", {63'd0, bus.tri_ready}, 64'd1);
      end else begin
        check_eq("first_valid_latency", {63'd0, bus.out_valid}, 64'd1);
      end
    end
  endtask

  task automatic wait_done(input string tag, input int base, input int n);
    bit done;
    int t;
    done = 0;
    t = 0;
    while (!done && t < 5000) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.busy) done = 1;
      t++;
    end
    if (!done) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    check_eq({tag, "_handshakes"}, 64'(hs_count - base), 64'(n));
  endtask

  initial begin
    int base, n, n2;
    bus.tri_valid = 1'b0;
    bus.vertex_ax = '0; bus.vertex_ay = '0;
    bus.vertex_bx = '0; bus.vertex_by = '0;
    bus.vertex_cx = '0; bus.vertex_cy = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tri_ready", {63'd0, bus.tri_ready}, 64'd0);
    check_eq("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check_eq("rst_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("rst_skipped", {63'd0, bus.tri_skipped}, 64'd0);
    check_eq("rst_point", pack_pix(int'(bus.point_px), int'(bus.point_py), bus.out_last),
             pack_pix(0, 0, 0));
    check_eq("rst_verts", pack_verts(int'(bus.out_ax), int'(bus.out_ay), int'(bus.out_bx),
                                     int'(bus.out_by), int'(bus.out_cx), int'(bus.out_cy)),
             pack_verts(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_tri_ready", {63'd0, bus.tri_ready}, 64'd1);

    // 4x4 box, full throughput
    base = hs_count;
    send_tri(2, 3, 5, 3, 2, 6, n);
    wait_done("box16", base, n);

    // same box under 1,0,0,1 backpressure
    stall_mode = 1;
    base = hs_count;
    send_tri(2, 3, 5, 3, 2, 6, n);
    wait_done("box16_stall", base, n);
    stall_mode = 0;

    // single-pixel degenerate triangle
    base = hs_count;
    send_tri(7, 7, 7, 7, 7, 7, n);
    wait_done("single", base, n);

    // clamped at bottom-right corner: 10x10
    base = hs_count;
    send_tri(630, 470, 700, 500, 635, 475, n);
    wait_done("corner", base, n);

    // fully off-screen in x
    base = hs_count;
    send_tri(650, 10, 700, 20, 660, 30, n);
    wait_done("offscreen", base, n);

    // second triangle held on tri_valid during a scan
    base = hs_count;
    send_tri(2, 3, 5, 3, 2, 6, n);
    send_tri(10, 20, 12, 20, 10, 21, n2);
    wait_done("back_to_back", base, n + n2);

    // reset right after the 5th pixel
    base = hs_count;
    send_tri(2, 3, 5, 3, 2, 6, n);
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      #1;
      if (hs_count - base >= 5) break;
    end
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_handshakes", 64'(hs_count - base), 64'd5);
    check_eq("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check_eq("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("midrst_tri_ready", {63'd0, bus.tri_ready}, 64'd1);
    base = hs_count;
    send_tri(20, 10, 22, 11, 21, 12, n);
    wait_done("after_rst", base, n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tri_bbox_scanner.md
Name: tri_bbox_scanner

Overview:
Upstream pixel-generation stage of the triangle rasterizer. Accepts one triangle (three screen-space vertices), computes its screen-clamped axis-aligned bounding box, and walks it in raster order (x fastest, then y). Emits one candidate pixel per handshake, together with the held vertices, to the barycentric-coordinate stage. One triangle is in flight at a time.

Parameters:
WIDTH, 10, bit width of every coordinate (unsigned)
SCREEN_W, 640, horizontal resolution; x clamped to SCREEN_W-1
SCREEN_H, 480, vertical resolution; y clamped to SCREEN_H-1

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
tri_valid  in  1  triangle vertices valid
tri_ready  out  1  scanner can accept a triangle
vertex_ax, vertex_ay, vertex_bx, vertex_by, vertex_cx, vertex_cy  in  WIDTH each  triangle vertices
out_valid  out  1  candidate pixel valid
out_ready  in  1  downstream accepts pixel
out_ax, out_ay, out_bx, out_by, out_cx, out_cy  out  WIDTH each  latched vertices, stable for the whole triangle
point_px, point_py  out  WIDTH each  current pixel
out_last  out  1  current pixel is the final one of the bounding box
tri_skipped  out  1  one-cycle pulse: triangle fully off-screen, no pixels emitted
busy  out  1  state != IDLE

Behaviour:
- Reset values: tri_ready=0 during reset, then 1 in IDLE. out_valid=0, out_last=0, tri_skipped=0, busy=0. point_px/py, out_* vertices = 0. State = IDLE.
- States: IDLE, BOUND, SCAN.
- IDLE: tri_ready=1. On tri_valid&&tri_ready (cycle N), latch the six vertices and go to BOUND.
- BOUND (cycle N+1): xmin=min3(ax,bx,cx), xmax=min(max3(ax,bx,cx),SCREEN_W-1); same for y with SCREEN_H-1. If xmin>SCREEN_W-1 or ymin>SCREEN_H-1, pulse tri_skipped and return to IDLE. Otherwise load x=xmin, y=ymin and go to SCAN.
- SCAN: out_valid=1 from cycle N+2 at the earliest. out_last=(x==xmax)&&(y==ymax).
  - On out_valid&&out_ready: if out_last, go to IDLE with out_valid=0 the next cycle. Else if x==xmax, set x=xmin and y=y+1. Else set x=x+1.
  - When out_valid&&!out_ready: point_px/py, out_last and out_* hold unchanged. out_valid never drops without a handshake.
- tri_ready=0 in BOUND and SCAN. A tri_valid asserted during these states is not consumed.
- Degenerate and zero-area triangles are scanned normally. The bbox is always non-empty when on-screen: all vertices equal gives a single pixel with out_last=1.
- Arithmetic: all compares are unsigned at WIDTH bits. Counters never exceed xmax/ymax, so there is no wrap-around. WIDTH must hold SCREEN_W-1 and SCREEN_H-1.
- Throughput: one pixel per cycle while out_ready=1. Per-triangle overhead is 2 cycles (accept + BOUND). Minimum IDLE dwell after the last pixel is 1 cycle.
- Reset mid-operation: any state goes to IDLE next cycle. The current triangle is discarded and out_valid=0.

Decomposition:
- types_pkg: add bbox_t (xmin, xmax, ymin, ymax : WIDTH-bit logic), scan_state_t enum {IDLE, BOUND, SCAN}, and SCREEN_W/SCREEN_H localparam defaults. Reuse the existing vector_t for latched vertices.
- Sub-module bbox_calc: purely combinational. Three vector_t inputs in, clamped bbox_t plus off_screen flag out. It is instantiated once and registered in BOUND.

Test Plan:
- Triangle (2,3),(5,3),(2,6), out_ready=1 -> 16 pixels in order (2,3),(3,3)…(5,3),(2,4)…(5,6). The first out_valid comes 2 cycles after accept. out_last is high only on (5,6), and tri_ready returns the cycle after.
- Same triangle, out_ready toggled 1,0,0,1 repeatedly -> no pixel lost or duplicated, outputs stable while stalled, still exactly 16 handshakes.
- Vertices (7,7),(7,7),(7,7) -> exactly one pixel (7,7) with out_last=1. Vertices (630,470),(700,500),(635,475) -> bbox x630..639, y470..479, 100 pixels.
- Vertices (650,10),(700,20),(660,30) -> tri_skipped pulses for one cycle 1 cycle after accept, out_valid stays 0, back in IDLE.
- Second triangle presented with tri_valid held during a scan -> not accepted until the first triangle's out_last handshake, then accepted in IDLE and scanned with the new vertices on out_*.
- rst asserted after the 5th pixel of the 16-pixel triangle -> next cycle out_valid=0, busy=0, tri_ready=1. A new triangle then scans from its own xmin,ymin.
